instr_encoder: RTL
==================

# instr_encoder

Packs a decoded instruction request (operation, register numbers, 64-bit signed immediate) into a 32-bit RV64I machine word. It is the inverse of the immediate generator: it range-checks the immediate and scatters it into the I/S/SB bit fields. Encoded words are buffered in a 2-entry FIFO and tagged with a running instruction address. The block sits between the test/loader front end and the instruction memory write port.

## Interface

Parameters:
- `PC_RESET`, `64'h0`: address assigned to the first instruction after reset.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  request present
- `in_ready`  out  1  request accepted when `in_valid && in_ready`
- `in_op`  in  2  0=ADDI, 1=LD, 2=SD, 3=BEQ
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register numbers; unused fields are ignored
- `in_imm`  in  64  signed immediate (byte offset for BEQ)
- `pc_load`  in  1  load the address counter
- `pc_load_val`  in  64  new address counter value
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  head consumed when `out_valid && out_ready`
- `out_instr`  out  32  encoded word at FIFO head
- `out_addr`  out  64  address of that word
- `err_valid`  out  1  one-cycle pulse: an accepted request was rejected
- `err_code`  out  2  0=none, 1=RANGE, 2=ALIGN; held until the next error
- `err_count`  out  16  count of rejected requests, saturates at 16'hFFFF

## Operation

Encoding uses standard RV64I fields:
- ADDI: opcode 0010011, funct3 000, `imm[11:0]` in [31:20].
- LD: opcode 0000011, funct3 011, `imm[11:0]` in [31:20].
- SD: opcode 0100011, funct3 011, `imm[11:5]` in [31:25], `imm[4:0]` in [11:7], rs2 in [24:20].
- BEQ: opcode 1100011, funct3 000, `imm[12|10:5]` in [31:25], `imm[4:1|11]` in [11:7].

Range and alignment checks:
- ADDI, LD, SD: `in_imm` must equal the sign extension of `in_imm[11:0]`, i.e. lie in [-2048, 2047]. Otherwise the request is rejected with RANGE.
- BEQ: `in_imm` must lie in [-4096, 4094], otherwise RANGE. `in_imm[0]` must be 0, otherwise ALIGN. RANGE takes priority over ALIGN.

Address counter `pc`:
- Reset value is `PC_RESET`.
- Each valid accepted request is enqueued with `out_addr = pc`, then `pc` advances by 4 (wraps modulo 2^64).
- Rejected requests are not enqueued and do not advance `pc`.
- If `pc_load` is asserted: `pc_load_val` replaces `pc` for any request accepted in the same cycle. That request is tagged `pc_load_val` and `pc` becomes `pc_load_val+4`. With no accept, `pc` simply becomes `pc_load_val`.

FIFO behaviour:
- `in_ready = !full`, independent of `out_ready`. When full, no request is accepted, including requests that would be rejected.
- Push and pop in the same cycle with 1 entry: count stays 1, the new word becomes the head on the next cycle.
- Pop when empty is ignored.

## Timing

- Reset values: `in_ready=1`, `out_valid=0`, `out_instr=0`, `out_addr=0`, `err_valid=0`, `err_code=0`, `err_count=0`, `pc=PC_RESET`, FIFO empty.
- Reset mid-stream discards all FIFO contents and any pending error pulse in that same cycle.
- Latency: a request accepted at edge N is visible as `out_valid`/`out_instr` after edge N (registered encode, 1 cycle). This holds if the FIFO was empty, or if it reaches the head then.
- Error path: `err_valid` goes high for exactly the cycle after the accepting edge, and `err_code` updates at the same edge. Back-to-back errors give consecutive 1-cycle pulses.
- Throughput: 1 request per cycle sustained while `out_ready=1`.
- `out_instr`/`out_addr` remain stable while `out_valid && !out_ready`.

## Structure

- Package `instr_enc_pkg` holds:
  - op enum (ADDI/LD/SD/BEQ);
  - 7-bit opcode and 3-bit funct3 constants;
  - err_code constants.
- Sub-module `instr_enc_fifo`: a 2-entry, 96-bit-wide (instr+addr) synchronous FIFO with valid/ready on both sides. It is also reusable elsewhere.
- Top-level contents: combinational encode/check, `pc` register, error registers, FIFO instance.

## Test plan

- ADDI rd=1, rs1=0, imm=5, `PC_RESET=0` -> one cycle later `out_instr=32'h00500093`, `out_addr=0`.
- Back-to-back LD rd=2, rs1=1, imm=8, then SD rs2=2, rs1=1, imm=16, `out_ready=1` -> `32'h0080B103` @ addr 0, then `32'h0020B823` @ addr 4, no bubbles.
- BEQ rs1=1, rs2=2, imm=-8 -> `32'hFE208CE3`. BEQ imm=3 -> `err_valid` pulse, `err_code=2`, no enqueue, `pc` unchanged.
- ADDI imm=2048 -> `err_code=1`, `err_count=1`. Then ADDI imm=-2048 -> accepted, `out_instr=32'h80000013`.
- Hold `out_ready=0`, send 3 requests -> two accepted, `in_ready=0` on the third. Release `out_ready` -> drains in order, third then accepted.
- `pc_load`, `pc_load_val=64'h1000` in the same cycle as an ADDI accept -> `out_addr=64'h1000`, next instruction gets addr `64'h1004`. Assert `reset` with 2 entries queued -> `out_valid=0` next cycle.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV64I instruction encoder.
package instr_enc_pkg;

  typedef enum logic [1:0] {
    OP_ADDI = 2'd0,
    OP_LD   = 2'd1,
    OP_SD   = 2'd2,
    OP_BEQ  = 2'd3
  } op_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LD   = 3'b011;
  localparam logic [2:0] F3_SD   = 3'b011;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;

  localparam int unsigned ENTRY_W = 96;  // {addr[63:0], instr[31:0]}

endpackage

// File: rtl/instr_enc_fifo.sv
// Two-entry synchronous FIFO with valid/ready on both sides.
// in_ready_o depends only on fullness, never on out_ready_i.
module instr_enc_fifo #(
  parameter int unsigned W = 96
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_ready_i && out_valid_o;

  // Storage, pointers and occupancy; reset also clears the data so the head reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded ADDI/LD/SD/BEQ requests into RV64I words, range-checks the
// immediate, tags each word with a running address and queues it.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [63:0] in_imm,
  input  logic        pc_load,
  input  logic [63:0] pc_load_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_addr,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [15:0] err_count
);

  logic [63:0]        pc_q, pc_d, pc_base;
  logic               err_valid_q;
  logic [1:0]         err_code_q;
  logic [15:0]        err_count_q;
  logic [31:0]        enc;
  logic [1:0]         chk;
  logic               accept, push_ok;
  logic               imm12_ok, br_ok;
  logic signed [63:0] imm_s;
  logic [ENTRY_W-1:0] head;

  assign imm_s    = in_imm;
  assign imm12_ok = (in_imm == {{52{in_imm[11]}}, in_imm[11:0]});
  assign br_ok    = (imm_s >= -64'sd4096) && (imm_s <= 64'sd4094);

  // Scatter the immediate into the format of the selected op and classify it.
  always_comb begin
    enc = '0;
    chk = ERR_NONE;
    case (op_e'(in_op))
      OP_ADDI: begin
        enc = {in_imm[11:0], in_rs1, F3_ADDI, in_rd, OPC_OP_IMM};
        if (!imm12_ok) chk = ERR_RANGE;
      end
      OP_LD: begin
        enc = {in_imm[11:0], in_rs1, F3_LD, in_rd, OPC_LOAD};
        if (!imm12_ok) chk = ERR_RANGE;
      end
      OP_SD: begin
        enc = {in_imm[11:5], in_rs2, in_rs1, F3_SD, in_imm[4:0], OPC_STORE};
        if (!imm12_ok) chk = ERR_RANGE;
      end
      OP_BEQ: begin
        enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, F3_BEQ,
               in_imm[4:1], in_imm[11], OPC_BRANCH};
        // Out-of-range wins over misalignment.
        if (!br_ok)         chk = ERR_RANGE;
        else if (in_imm[0]) chk = ERR_ALIGN;
      end
      default: ;
    endcase
  end

  // Full FIFO blocks every request, good or bad, so accept gates both paths.
  assign accept  = in_valid && in_ready;
  assign push_ok = accept && (chk == ERR_NONE);
  assign pc_base = pc_load ? pc_load_val : pc_q;
  assign pc_d    = push_ok ? pc_base + 64'd4 : pc_base;

  instr_enc_fifo #(.W(ENTRY_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (accept && (chk == ERR_NONE)),
    .in_ready_o  (in_ready),
    .in_data_i   ({pc_base, enc}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head)
  );

  assign out_instr = head[31:0];
  assign out_addr  = head[95:32];

  // Address counter: advances only for words that were actually enqueued.
  always_ff @(posedge clk) begin
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  // Error pulse, sticky code and saturating reject counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      err_count_q <= '0;
    end else begin
      err_valid_q <= accept && (chk != ERR_NONE);
      if (accept && (chk != ERR_NONE)) begin
        err_code_q <= chk;
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;

endmodule
